// File: rtl/uart_bram_loader.sv
// uart_bram_loader: decodes UART bytes into core commands, or fills BRAM A/B sequentially after a load opcode.
// Latency: 1 cycle from rx_ready to command / bad_cmd / write strobe / write_done; every output is a flop.
// Backpressure: none; one byte per rx_ready, back-to-back accepted. Define UART_LOAD_TIMEOUT_EN for an inter-byte load timeout.
module uart_bram_loader #(
   parameter int N_BYTES        = 1024,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   input  logic       coprocessor_busy,
   output logic [2:0] command,
   output logic       ena_A,
   output logic       wea_A,
   output logic [9:0] addra_A,
   output logic [7:0] dina_A,
   output logic       ena_B,
   output logic       wea_B,
   output logic [9:0] addra_B,
   output logic [7:0] dina_B,
   output logic       loader_busy,
   output logic       write_done,
   output logic       bad_cmd
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD_A = 2'd1, LOAD_B = 2'd2} state_t;

   localparam logic [9:0] LAST_ADDR = 10'(N_BYTES - 1);
   localparam logic [7:0] OP_LOAD_A = 8'h11;
   localparam logic [7:0] OP_LOAD_B = 8'h12;

   state_t     state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   logic [2:0] command_q, command_d;
   logic       ena_a_q, ena_a_d, wea_a_q, wea_a_d;
   logic [9:0] addra_a_q, addra_a_d;
   logic [7:0] dina_a_q, dina_a_d;
   logic       ena_b_q, ena_b_d, wea_b_q, wea_b_d;
   logic [9:0] addra_b_q, addra_b_d;
   logic [7:0] dina_b_q, dina_b_d;
   logic       loader_busy_q, loader_busy_d;
   logic       write_done_q, write_done_d;
   logic       bad_cmd_q, bad_cmd_d;
   logic       tmo_hit;

`ifdef UART_LOAD_TIMEOUT_EN
   localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_q, tmo_d;

   // Abort the load when TIMEOUT_CYCLES edges pass without a byte.
   assign tmo_hit = (state_q != IDLE) && !rx_ready && (tmo_q == TMO_LAST);

   // Idle-cycle counter: runs only inside a load, restarts on every byte.
   always_comb begin
      tmo_d = '0;
      if (state_q != IDLE && !rx_ready && !tmo_hit) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   // Idle-cycle counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end
`else
   // No timeout hardware: a load waits forever; the parameter only keeps the interface uniform.
   assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   // Opcode decode in IDLE, data write path in LOAD_x; pulses default low, BRAM address/data hold.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      command_d    = 3'd0;
      bad_cmd_d    = 1'b0;
      write_done_d = 1'b0;
      ena_a_d      = 1'b0;
      wea_a_d      = 1'b0;
      addra_a_d    = addra_a_q;
      dina_a_d     = dina_a_q;
      ena_b_d      = 1'b0;
      wea_b_d      = 1'b0;
      addra_b_d    = addra_b_q;
      dina_b_d     = dina_b_q;
      case (state_q)
         IDLE: begin
            if (rx_ready) begin
               if (rx_data[7:3] == 5'd0 && rx_data[2:0] != 3'd0) begin
                  // Core commands are refused rather than queued while the core is busy.
                  if (coprocessor_busy) bad_cmd_d = 1'b1;
                  else                  command_d = rx_data[2:0];
               end else if (rx_data == OP_LOAD_A) begin
                  state_d = LOAD_A;
                  cnt_d   = 10'd0;
               end else if (rx_data == OP_LOAD_B) begin
                  state_d = LOAD_B;
                  cnt_d   = 10'd0;
               end else begin
                  bad_cmd_d = 1'b1;
               end
            end
         end
         LOAD_A, LOAD_B: begin
            if (rx_ready) begin
               if (state_q == LOAD_A) begin
                  ena_a_d   = 1'b1;
                  wea_a_d   = 1'b1;
                  addra_a_d = cnt_q;
                  dina_a_d  = rx_data;
               end else begin
                  ena_b_d   = 1'b1;
                  wea_b_d   = 1'b1;
                  addra_b_d = cnt_q;
                  dina_b_d  = rx_data;
               end
               if (cnt_q == LAST_ADDR) begin
                  write_done_d = 1'b1;
                  cnt_d        = 10'd0;
                  state_d      = IDLE;
               end else begin
                  cnt_d = cnt_q + 10'd1;
               end
            end else if (tmo_hit) begin
               bad_cmd_d = 1'b1;
               cnt_d     = 10'd0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      loader_busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset aborts any load and zeroes every output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         command_q     <= '0;
         ena_a_q       <= 1'b0;
         wea_a_q       <= 1'b0;
         addra_a_q     <= '0;
         dina_a_q      <= '0;
         ena_b_q       <= 1'b0;
         wea_b_q       <= 1'b0;
         addra_b_q     <= '0;
         dina_b_q      <= '0;
         loader_busy_q <= 1'b0;
         write_done_q  <= 1'b0;
         bad_cmd_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         command_q     <= command_d;
         ena_a_q       <= ena_a_d;
         wea_a_q       <= wea_a_d;
         addra_a_q     <= addra_a_d;
         dina_a_q      <= dina_a_d;
         ena_b_q       <= ena_b_d;
         wea_b_q       <= wea_b_d;
         addra_b_q     <= addra_b_d;
         dina_b_q      <= dina_b_d;
         loader_busy_q <= loader_busy_d;
         write_done_q  <= write_done_d;
         bad_cmd_q     <= bad_cmd_d;
      end
   end

   assign command     = command_q;
   assign ena_A       = ena_a_q;
   assign wea_A       = wea_a_q;
   assign addra_A     = addra_a_q;
   assign dina_A      = dina_a_q;
   assign ena_B       = ena_b_q;
   assign wea_B       = wea_b_q;
   assign addra_B     = addra_b_q;
   assign dina_B      = dina_b_q;
   assign loader_busy = loader_busy_q;
   assign write_done  = write_done_q;
   assign bad_cmd     = bad_cmd_q;

endmodule
